// File: rtl/concat_packer.sv
// Packs NUM_LANES narrow beats into one wide word, with optional early flush on in_last.
// Latency: out_valid rises one cycle after the closing beat is accepted.
// Backpressure: in_ready drops while a word is held unconsumed; the accumulator holds.
module concat_packer #(
    parameter int                LANE_W    = 1,
    parameter int                NUM_LANES = 4,
    parameter bit                MSB_FIRST = 1'b0,
    parameter logic [LANE_W-1:0] PAD       = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANE_W-1:0]                in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANE_W*NUM_LANES-1:0]      out_data,
    output logic [$clog2(NUM_LANES+1)-1:0]   out_count,
    output logic                             out_last
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam int CNT_W = $clog2(NUM_LANES + 1);

    typedef logic [NUM_LANES-1:0][LANE_W-1:0] word_t;
    localparam word_t PAD_WORD = {NUM_LANES{PAD}};

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] lane;
    word_t            acc;
    word_t            acc_nxt;
    logic             accept;
    logic             close;

    // A word may close in the same cycle the previous one is consumed.
    assign in_ready = rst_n & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign close    = accept & ((idx == IDX_W'(NUM_LANES - 1)) | in_last);
    assign lane     = MSB_FIRST ? (IDX_W'(NUM_LANES - 1) - idx) : idx;

    always_comb begin
        acc_nxt       = acc;
        acc_nxt[lane] = in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            idx       <= '0;
            acc       <= PAD_WORD;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (close) begin
                    out_valid <= 1'b1;
                    out_data  <= acc_nxt;
                    out_count <= CNT_W'(idx) + CNT_W'(1);
                    out_last  <= in_last;
                    acc       <= PAD_WORD;
                    idx       <= '0;
                end else begin
                    acc <= acc_nxt;
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule
